// File: rtl/pkt_cnt_pkg.sv
// Shared constants and FSM encoding for the packet/byte counter reader.
package pkt_cnt_pkg;
  localparam int BYTE_COUNTER_WIDTH   = 37;
  localparam int PACKET_COUNTER_WIDTH = 27;

  localparam int CNT_ADR_INDEX = 0;
  localparam int CNT_ADR_LOW   = 1;
  localparam int CNT_ADR_HIGH  = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_SETTLE,
    ST_RDL_REQ,
    ST_RDL_WAIT,
    ST_RDH_REQ,
    ST_RDH_WAIT,
    ST_RESULT
  } state_e;
endpackage

// File: rtl/packet_counter_reader_if.sv
// Wishbone single-transfer bus between the reader and the counter block.
interface packet_counter_reader_if #(
  parameter int AW = 24,
  parameter int DW = 32
) ();
  logic          cyc;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          ack;
  logic [DW-1:0] dat_r;

  modport master (output cyc, we, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, we, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/packet_counter_reader_wb_single_master.sv
// One Wishbone transfer: one-cycle cyc pulse, held adr/we/dat, ack wait with timeout.
module wb_single_master #(
  parameter int AW             = 24,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  output logic          done_o,
  output logic          err_o,
  output logic [DW-1:0] rdata_o,
  packet_counter_reader_if.master wb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ack_ok, expired;

  always_comb begin
    cyc_d  = 1'b0;
    we_d   = we_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    busy_d = busy_q;
    tmo_d  = tmo_q;
    // an ack coinciding with our own pulse cannot belong to this transfer
    ack_ok  = busy_q && !cyc_q && wb.ack;
    expired = busy_q && !ack_ok && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    done_o  = ack_ok || expired;
    err_o   = expired;
    if (busy_q) tmo_d = tmo_q + 1'b1;
    if (done_o) busy_d = 1'b0;
    if (start_i) begin
      cyc_d  = 1'b1;
      busy_d = 1'b1;
      tmo_d  = '0;
      we_d   = we_i;
      adr_d  = adr_i;
      dat_d  = dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cyc_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      dat_q  <= '0;
      busy_q <= 1'b0;
      tmo_q  <= '0;
    end else begin
      cyc_q  <= cyc_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      busy_q <= busy_d;
      tmo_q  <= tmo_d;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;
  assign rdata_o  = wb.dat_r;
endmodule

// File: rtl/packet_counter_reader.sv
// Reads 64-bit packet/byte statistics entries over Wishbone: index write, settle, low read, high read.
module packet_counter_reader
  import pkt_cnt_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 24,
  parameter int NUM_COUNTER    = 1024,
  parameter int IDX_WIDTH      = 10,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            req_valid_i,
  input  logic [IDX_WIDTH-1:0]            req_idx_i,
  input  logic                            scan_i,
  output logic                            req_ready_o,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [IDX_WIDTH-1:0]            res_idx_o,
  output logic [PACKET_COUNTER_WIDTH-1:0] res_packets_o,
  output logic [BYTE_COUNTER_WIDTH-1:0]   res_bytes_o,
  output logic                            res_err_o,
  output logic                            res_last_o,
  output logic                            busy_o,
  output logic                            wb_cyc_o,
  output logic                            wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]        wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0]        wb_dat_o,
  input  logic                            wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0]        wb_dat_i
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_COUNTER - 1);

  packet_counter_reader_if #(.AW(WB_ADDR_WIDTH), .DW(WB_DATA_WIDTH)) bus ();

  state_e                            state_q, state_d;
  logic [IDX_WIDTH-1:0]              idx_q, idx_d;
  logic                              scan_q, scan_d;
  logic [SW-1:0]                     settle_q, settle_d;
  logic [WB_DATA_WIDTH-1:0]          lo_q, lo_d, hi_d;
  logic                              req_ready_q, res_valid_q, res_err_q, res_last_q, busy_q;
  logic                              res_err_d, res_last_d;
  logic [IDX_WIDTH-1:0]              res_idx_q, res_idx_d;
  logic [PACKET_COUNTER_WIDTH-1:0]   res_packets_q, res_packets_d;
  logic [BYTE_COUNTER_WIDTH-1:0]     res_bytes_q, res_bytes_d;
  logic [2*WB_DATA_WIDTH-1:0]        res_data;
  logic                              fin_err;

  logic                              m_start, m_we, m_done, m_err;
  logic [WB_ADDR_WIDTH-1:0]          m_adr;
  logic [WB_DATA_WIDTH-1:0]          m_rdata;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scan_d   = scan_q;
    settle_d = settle_q;
    lo_d     = lo_q;
    hi_d     = '0;
    fin_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_ready_q && scan_i) begin
          idx_d   = '0;
          scan_d  = 1'b1;
          state_d = ST_WR_REQ;
        end else if (req_ready_q && req_valid_i) begin
          idx_d   = req_idx_i;
          scan_d  = 1'b0;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ:  state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (m_done && m_err) begin
          fin_err = 1'b1;
          state_d = ST_RESULT;
        end else if (m_done) begin
          settle_d = SW'(SETTLE_CYCLES);
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_RDL_REQ;
        else                settle_d = settle_q - 1'b1;
      end
      ST_RDL_REQ:  state_d = ST_RDL_WAIT;
      ST_RDL_WAIT: begin
        if (m_done && m_err) begin
          fin_err = 1'b1;
          state_d = ST_RESULT;
        end else if (m_done) begin
          lo_d    = m_rdata;
          state_d = ST_RDH_REQ;
        end
      end
      ST_RDH_REQ:  state_d = ST_RDH_WAIT;
      ST_RDH_WAIT: begin
        if (m_done) begin
          fin_err = m_err;
          hi_d    = m_rdata;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready_i) begin
          if (scan_q && idx_q < LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result fields are loaded once on entry into RESULT and then held.
  always_comb begin
    res_idx_d     = res_idx_q;
    res_packets_d = res_packets_q;
    res_bytes_d   = res_bytes_q;
    res_err_d     = res_err_q;
    res_last_d    = res_last_q;
    res_data      = fin_err ? '0 : {hi_d, lo_q};
    if (state_d == ST_RESULT && state_q != ST_RESULT) begin
      res_idx_d     = idx_q;
      res_packets_d = res_data[2*WB_DATA_WIDTH-1 -: PACKET_COUNTER_WIDTH];
      res_bytes_d   = res_data[BYTE_COUNTER_WIDTH-1:0];
      res_err_d     = fin_err;
      res_last_d    = !scan_q || (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    m_start = (state_d == ST_WR_REQ) || (state_d == ST_RDL_REQ) || (state_d == ST_RDH_REQ);
    m_we    = (state_d == ST_WR_REQ);
    m_adr   = (state_d == ST_WR_REQ)  ? WB_ADDR_WIDTH'(CNT_ADR_INDEX) :
              (state_d == ST_RDL_REQ) ? WB_ADDR_WIDTH'(CNT_ADR_LOW)   :
                                        WB_ADDR_WIDTH'(CNT_ADR_HIGH);
  end

  wb_single_master #(
    .AW(WB_ADDR_WIDTH), .DW(WB_DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wbm (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (m_start),
    .we_i    (m_we),
    .adr_i   (m_adr),
    .dat_i   (WB_DATA_WIDTH'(idx_d)),
    .done_o  (m_done),
    .err_o   (m_err),
    .rdata_o (m_rdata),
    .wb      (bus)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      scan_q        <= 1'b0;
      settle_q      <= '0;
      lo_q          <= '0;
      req_ready_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      res_idx_q     <= '0;
      res_packets_q <= '0;
      res_bytes_q   <= '0;
      res_err_q     <= 1'b0;
      res_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      scan_q        <= scan_d;
      settle_q      <= settle_d;
      lo_q          <= lo_d;
      req_ready_q   <= (state_d == ST_IDLE);
      res_valid_q   <= (state_d == ST_RESULT);
      busy_q        <= (state_d != ST_IDLE);
      res_idx_q     <= res_idx_d;
      res_packets_q <= res_packets_d;
      res_bytes_q   <= res_bytes_d;
      res_err_q     <= res_err_d;
      res_last_q    <= res_last_d;
    end
  end

  assign bus.ack       = wb_ack_i;
  assign bus.dat_r     = wb_dat_i;
  assign wb_cyc_o      = bus.cyc;
  assign wb_we_o       = bus.we;
  assign wb_adr_o      = bus.adr;
  assign wb_dat_o      = bus.dat_w;
  assign req_ready_o   = req_ready_q;
  assign res_valid_o   = res_valid_q;
  assign busy_o        = busy_q;
  assign res_idx_o     = res_idx_q;
  assign res_packets_o = res_packets_q;
  assign res_bytes_o   = res_bytes_q;
  assign res_err_o     = res_err_q;
  assign res_last_o    = res_last_q;
endmodule

// File: tb/tb_packet_counter_reader.sv
// Bench: behavioural Wishbone counter-block slave plus directed and random reads of its entries.
module tb_packet_counter_reader;
  localparam int S   = 8;
  localparam int T   = 20;
  localparam int N   = 4;
  localparam logic [63:0] P37 = 64'h20_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, scan_i, res_ready_i;
  logic [9:0]  req_idx_i;
  logic        req_ready_o, res_valid_o, res_err_o, res_last_o, busy_o;
  logic [9:0]  res_idx_o;
  logic [26:0] res_packets_o;
  logic [36:0] res_bytes_o;

  packet_counter_reader_if #(.AW(24), .DW(32)) wb ();

  packet_counter_reader #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(24), .NUM_COUNTER(N), .IDX_WIDTH(10),
    .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid_i), .req_idx_i(req_idx_i), .scan_i(scan_i),
    .req_ready_o(req_ready_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_idx_o(res_idx_o), .res_packets_o(res_packets_o), .res_bytes_o(res_bytes_o),
    .res_err_o(res_err_o), .res_last_o(res_last_o), .busy_o(busy_o),
    .wb_cyc_o(wb.cyc), .wb_we_o(wb.we), .wb_adr_o(wb.adr), .wb_dat_o(wb.dat_w),
    .wb_ack_i(wb.ack), .wb_dat_i(wb.dat_r)
  );

  always #5 clk = ~clk;

  // counter-block model: acks two cycles after the pulse, reads return the selected entry
  logic [63:0] mem [16];
  logic [63:0] log_q [$];
  logic [9:0]  sel = '0;
  logic        ack_s = 1'b0, spur = 1'b0, pend = 1'b0, p_we = 1'b0, prev_cyc = 1'b0;
  logic [23:0] p_adr = '0;
  logic [31:0] p_dat = '0;
  int          noack_adr = -1;
  int          pulses = 0, dbl = 0;
  int          total = 0, bad = 0;

  assign wb.ack = ack_s | spur;

  always @(posedge clk) begin
    ack_s <= 1'b0;
    if (pend) begin
      pend <= 1'b0;
      if (int'(p_adr) != noack_adr) begin
        ack_s <= 1'b1;
        if (p_we) sel <= p_dat[9:0];
        else if (p_adr == 24'd1) wb.dat_r <= mem[sel[3:0]][31:0];
        else wb.dat_r <= mem[sel[3:0]][63:32];
      end
    end else if (wb.cyc && !ack_s) begin
      pend  <= 1'b1;
      p_we  <= wb.we;
      p_adr <= wb.adr;
      p_dat <= wb.dat_w;
      log_q.push_back({7'd0, wb.we, wb.adr, wb.dat_w});
    end
  end

  always @(posedge clk) begin
    if (wb.cyc) pulses <= pulses + 1;
    if (wb.cyc && prev_cyc) dbl <= dbl + 1;
    prev_cyc <= wb.cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ready_timeout", 64'(req_ready_o), 64'd1);
  endtask

  // issue a single read at a negedge; lat = posedges from acceptance to res_valid_o
  task automatic issue(input logic [9:0] idx, input int spur_at, output int lat);
    wait_ready();
    req_valid_i = 1'b1;
    req_idx_i   = idx;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 0;
    while (!res_valid_o && lat < 600) begin
      @(negedge clk);
      lat++;
      spur = (lat == spur_at);
    end
    spur = 1'b0;
    if (lat >= 600) chk("result_timeout", 64'(res_valid_o), 64'd1);
  endtask

  task automatic chk_entry(input string tag, input logic [9:0] idx);
    chk({tag, "_idx"}, 64'(res_idx_o), 64'(idx));
    chk({tag, "_pkts"}, 64'(res_packets_o), mem[idx[3:0]] / P37);
    chk({tag, "_bytes"}, 64'(res_bytes_o), mem[idx[3:0]] % P37);
    chk({tag, "_err"}, 64'(res_err_o), 64'd0);
  endtask

  initial begin
    int lat, p0, got, vcnt;
    logic prev_v, prev_r;
    logic [63:0] snap_a;
    logic [11:0] snap_b;
    logic [9:0]  ridx;

    rst_n = 1'b0; req_valid_i = 1'b0; req_idx_i = '0; scan_i = 1'b0; res_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    #12;
    chk("rst_ctl", 64'({res_valid_o, res_idx_o, res_err_o, res_last_o, busy_o, req_ready_o}), 64'd0);
    chk("rst_data", {res_packets_o, res_bytes_o}, 64'd0);
    chk("rst_wb", 64'({wb.cyc, wb.we, wb.adr, wb.dat_w}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // entry 5 single read: one write of the index then low and high reads
    mem[5] = 64'h0000_0003_0000_05DC;
    log_q.delete();
    p0 = pulses;
    issue(10'd5, 0, lat);
    chk("t1_lat", 64'(lat), 64'(10 + S));
    chk("t1_pkts", 64'(res_packets_o), 64'd0);
    chk("t1_bytes", 64'(res_bytes_o), 64'h3_0000_05DC);
    chk("t1_last", 64'(res_last_o), 64'd1);
    chk_entry("t1", 10'd5);
    @(negedge clk);
    chk("t1_pulses", 64'(pulses - p0), 64'd3);
    chk("t1_log_n", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      chk("t1_log_wr", log_q[0], {7'd0, 1'b1, 24'd0, 32'd5});
      chk("t1_log_rdl", 64'(log_q[1][56:32]), 64'd1);
      chk("t1_log_rdh", 64'(log_q[2][56:32]), 64'd2);
    end

    // packets=1000, bytes=64000
    mem[7] = 64'd1000 * P37 + 64'd64000;
    issue(10'd7, 0, lat);
    chk("t2_pkts", 64'(res_packets_o), 64'd1000);
    chk("t2_bytes", 64'(res_bytes_o), 64'd64000);
    @(negedge clk);

    // random single reads
    repeat (6) begin
      ridx = 10'($urandom_range(0, 15));
      mem[ridx[3:0]] = {$urandom, $urandom};
      issue(ridx, 0, lat);
      chk_entry("rnd", ridx);
      chk("rnd_last", 64'(res_last_o), 64'd1);
      @(negedge clk);
    end

    // spurious ack during SETTLE is ignored
    log_q.delete();
    p0 = pulses;
    mem[9] = {$urandom, $urandom};
    issue(10'd9, 6, lat);
    chk("spur_lat", 64'(lat), 64'(10 + S));
    chk_entry("spur", 10'd9);
    @(negedge clk);
    chk("spur_pulses", 64'(pulses - p0), 64'd3);

    // low read never acked: error result T cycles after its pulse
    noack_adr = 1;
    issue(10'd2, 0, lat);
    chk("tmo_lat", 64'(lat), 64'(4 + S + T));
    chk("tmo_err", 64'(res_err_o), 64'd1);
    chk("tmo_data", {res_packets_o, res_bytes_o}, 64'd0);
    chk("tmo_last", 64'(res_last_o), 64'd1);
    noack_adr = -1;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_idle", 64'({req_ready_o, busy_o, res_valid_o}), 64'b100);

    // scan (wins over a simultaneous single request) with ready toggling
    res_ready_i = 1'b0;
    wait_ready();
    scan_i = 1'b1; req_valid_i = 1'b1; req_idx_i = 10'd9;
    @(negedge clk);
    scan_i = 1'b0; req_valid_i = 1'b0;
    got = 0; prev_v = 1'b0; prev_r = 1'b0; snap_a = '0; snap_b = '0;
    for (int c = 0; c < 2000 && got < N; c++) begin
      if (prev_v && !prev_r) begin
        chk("scan_hold_v", 64'(res_valid_o), 64'd1);
        chk("scan_hold_a", {res_packets_o, res_bytes_o}, snap_a);
        chk("scan_hold_b", 64'({res_idx_o, res_err_o, res_last_o}), 64'(snap_b));
      end
      if (res_valid_o) begin
        snap_a = {res_packets_o, res_bytes_o};
        snap_b = {res_idx_o, res_err_o, res_last_o};
      end
      prev_v = res_valid_o;
      res_ready_i = ~res_ready_i;
      prev_r = res_ready_i;
      if (res_valid_o && res_ready_i) begin
        chk_entry("scan", 10'(got));
        chk("scan_last", 64'(res_last_o), 64'(got == N - 1));
        got++;
      end
      @(negedge clk);
    end
    chk("scan_count", 64'(got), 64'(N));
    res_ready_i = 1'b1;
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (res_valid_o) vcnt++; end
    chk("scan_stop", 64'(vcnt), 64'd0);
    chk("scan_idle", 64'(req_ready_o), 64'd1);

    // reset pulsed in SETTLE: outputs clear at once, nothing emitted, next read fine
    wait_ready();
    req_valid_i = 1'b1; req_idx_i = 10'd3;
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ctl", 64'({res_valid_o, res_idx_o, res_err_o, res_last_o, busy_o, req_ready_o}), 64'd0);
    chk("arst_wb", 64'({wb.cyc, wb.we, wb.adr, wb.dat_w}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin @(negedge clk); if (res_valid_o) vcnt++; end
    chk("arst_no_res", 64'(vcnt), 64'd0);
    mem[3] = {$urandom, $urandom};
    issue(10'd3, 0, lat);
    chk("arst_lat", 64'(lat), 64'(10 + S));
    chk_entry("arst", 10'd3);
    @(negedge clk);

    chk("cyc_one_cycle", 64'(dbl), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
